// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: shares the register-file write port between execute and load.
// Define WB_RR_EN for round-robin arbitration; otherwise execute has fixed priority.
module regfile_wb_sched #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            req0_valid,
   input  logic [AW-1:0]   req0_addr,
   input  logic [XLEN-1:0] req0_data,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [AW-1:0]   req1_addr,
   input  logic [XLEN-1:0] req1_data,
   output logic            req1_ready,
   output logic            wr,
   output logic [AW-1:0]   waddr,
   output logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddrA,
   input  logic [AW-1:0]   raddrB,
   output logic            busyA,
   output logic            busyB,
   output logic            idle
);

   localparam int NR = 1 << AW;

   logic            g0, g1, acc;
   logic [AW-1:0]   a_addr;
   logic [XLEN-1:0] a_data;
   logic            wr_q, wr_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [NR-1:0]   sb_q, sb_d;

`ifdef WB_RR_EN
   // last_q = 1 means source 1 was granted last, so source 0 wins next
   logic last_q, last_d;

   always_comb begin
      g0 = req0_valid & (~req1_valid | last_q);
      g1 = req1_valid & (~req0_valid | ~last_q);
   end

   always_comb begin
      last_d = last_q;
      if (acc) last_d = g1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_q <= 1'b1;
      else       last_q <= last_d;
   end
`else
   assign g0 = req0_valid;
   assign g1 = req1_valid & ~req0_valid;
`endif

   assign req0_ready = g0;
   assign req1_ready = g1;
   assign acc        = g0 | g1;
   assign a_addr     = g1 ? req1_addr : req0_addr;
   assign a_data     = g1 ? req1_data : req0_data;

   always_comb begin
      wr_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (acc) begin
         wr_d    = (a_addr != '0);
         waddr_d = a_addr;
         wdata_d = a_data;
      end
   end

   // Set after clear: a re-issue in the accept cycle keeps the bit busy
   always_comb begin
      sb_d = sb_q;
      if (acc) sb_d[a_addr] = 1'b0;
      if (issue_valid && issue_rd != '0) sb_d[issue_rd] = 1'b1;
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         sb_q    <= '0;
      end else begin
         wr_q    <= wr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         sb_q    <= sb_d;
      end
   end

   assign wr    = wr_q;
   assign waddr = waddr_q;
   assign wdata = wdata_q;
   assign busyA = (raddrA != '0) & sb_q[raddrA];
   assign busyB = (raddrB != '0) & sb_q[raddrB];
   assign idle  = ~(|sb_q) & ~wr_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed scenarios plus a
// randomized run against a behavioural scoreboard/arbiter model.
module tb_regfile_wb_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_addr, req1_addr;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        wr;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddrA, raddrB;
   logic        busyA, busyB, idle;

   int checks   = 0;
   int failures = 0;

`ifdef WB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   regfile_wb_sched #(.XLEN(32), .AW(5)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .req0_valid(req0_valid), .req0_addr(req0_addr),
      .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr),
      .req1_data(req1_data), .req1_ready(req1_ready),
      .wr(wr), .waddr(waddr), .wdata(wdata),
      .raddrA(raddrA), .raddrB(raddrB),
      .busyA(busyA), .busyB(busyB), .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic clr_inputs();
      issue_valid = 0; issue_rd = 0;
      req0_valid = 0; req0_addr = 0; req0_data = 0;
      req1_valid = 0; req1_addr = 0; req1_data = 0;
   endtask

   task automatic do_reset();
      clr_inputs();
      raddrA = 0; raddrB = 0;
      reset = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      raddrA = 5; raddrB = 7;
      #1;
      checks++; if (wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%0b exp=0", wr); end
      checks++; if (waddr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
      checks++; if (wdata !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
      checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL reset_busyA got=%0b exp=0", busyA); end
      checks++; if (busyB !== 1'b0) begin failures++; $display("FAIL reset_busyB got=%0b exp=0", busyB); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%0b exp=1", idle); end
   endtask

   task automatic test_raw_hazard();
      do_reset();
      @(negedge clk);
      issue_valid = 1; issue_rd = 5; raddrA = 5;
      #1;
      checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL raw_busy_pre got=%0b exp=0", busyA); end
      @(negedge clk);
      issue_valid = 0;
      #1;
      checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL raw_busy_set got=%0b exp=1", busyA); end
      checks++; if (idle !== 1'b0) begin failures++; $display("FAIL raw_idle got=%0b exp=0", idle); end
      @(negedge clk);
      #1;
      checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL raw_busy_wait got=%0b exp=1", busyA); end
      @(negedge clk);
      req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL raw_ready got=%0b exp=1", req0_ready); end
      checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL raw_busy_acc got=%0b exp=1", busyA); end
      @(negedge clk);
      req0_valid = 0;
      #1;
      checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL raw_busy_clr got=%0b exp=0", busyA); end
      checks++; if (wr !== 1'b1) begin failures++; $display("FAIL raw_wr got=%0b exp=1", wr); end
      checks++; if (waddr !== 5'd5) begin failures++; $display("FAIL raw_waddr got=%0d exp=5", waddr); end
      checks++; if (wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_wdata got=%h exp=deadbeef", wdata); end
      @(negedge clk);
      #1;
      checks++; if (wr !== 1'b0) begin failures++; $display("FAIL raw_wr_off got=%0b exp=0", wr); end
      checks++; if (waddr !== 5'd5) begin failures++; $display("FAIL raw_waddr_hold got=%0d exp=5", waddr); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL raw_idle_end got=%0b exp=1", idle); end
   endtask

   task automatic test_contention();
      int          g, pg;
      logic [31:0] pd;
      do_reset();
      pg = -1; pd = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 4) begin
            req0_valid = 1; req0_addr = 1;
            req1_valid = 1; req1_addr = 2;
            if (i == 0 || pg == 0) req0_data = $urandom;
            if (i == 0 || pg == 1) req1_data = $urandom;
         end else begin
            clr_inputs();
         end
         #1;
         if (pg >= 0) begin
            checks++; if (wr !== 1'b1) begin failures++; $display("FAIL cont_wr[%0d] got=%0b exp=1", i, wr); end
            checks++; if (waddr !== 5'(pg + 1)) begin failures++; $display("FAIL cont_waddr[%0d] got=%0d exp=%0d", i, waddr, pg + 1); end
            checks++; if (wdata !== pd) begin failures++; $display("FAIL cont_wdata[%0d] got=%h exp=%h", i, wdata, pd); end
         end
         if (i < 4) begin
            g = RR ? (i % 2) : 0;
            checks++; if (req0_ready !== (g == 0)) begin failures++; $display("FAIL cont_ready0[%0d] got=%0b exp=%0b", i, req0_ready, g == 0); end
            checks++; if (req1_ready !== (g == 1)) begin failures++; $display("FAIL cont_ready1[%0d] got=%0b exp=%0b", i, req1_ready, g == 1); end
            pg = g;
            pd = (g == 0) ? req0_data : req1_data;
         end
      end
   endtask

   task automatic test_x0();
      do_reset();
      @(negedge clk);
      req1_valid = 1; req1_addr = 0; req1_data = 32'h1234;
      issue_valid = 1; issue_rd = 0; raddrA = 0;
      #1;
      checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%0b exp=1", req1_ready); end
      checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL x0_ready0 got=%0b exp=0", req0_ready); end
      @(negedge clk);
      clr_inputs();
      #1;
      checks++; if (wr !== 1'b0) begin failures++; $display("FAIL x0_wr got=%0b exp=0", wr); end
      checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL x0_busy got=%0b exp=0", busyA); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL x0_idle got=%0b exp=1", idle); end
   endtask

   task automatic test_set_clear_same_cycle();
      do_reset();
      raddrA = 7;
      @(negedge clk);
      issue_valid = 1; issue_rd = 7;
      @(negedge clk);
      req0_valid = 1; req0_addr = 7; req0_data = 32'hA5A5_0001;
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL sc_ready got=%0b exp=1", req0_ready); end
      checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL sc_busy_acc got=%0b exp=1", busyA); end
      @(negedge clk);
      clr_inputs();
      #1;
      checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL sc_busy_kept got=%0b exp=1", busyA); end
      checks++; if (wr !== 1'b1) begin failures++; $display("FAIL sc_wr got=%0b exp=1", wr); end
      checks++; if (waddr !== 5'd7) begin failures++; $display("FAIL sc_waddr got=%0d exp=7", waddr); end
      @(negedge clk);
      req0_valid = 1; req0_addr = 7; req0_data = 32'hA5A5_0002;
      #1;
      checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL sc_busy_2nd got=%0b exp=1", busyA); end
      @(negedge clk);
      clr_inputs();
      #1;
      checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL sc_busy_clr got=%0b exp=0", busyA); end
      checks++; if (wdata !== 32'hA5A5_0002) begin failures++; $display("FAIL sc_wdata got=%h exp=a5a50002", wdata); end
   endtask

   task automatic test_async_reset();
      do_reset();
      raddrA = 3; raddrB = 6;
      @(negedge clk);
      issue_valid = 1; issue_rd = 3;
      @(negedge clk);
      issue_rd = 4;
      @(negedge clk);
      issue_rd = 6;
      req0_valid = 1; req0_addr = 9; req0_data = 32'hCAFE_F00D;
      @(negedge clk);
      clr_inputs();
      #1;
      checks++; if (wr !== 1'b1) begin failures++; $display("FAIL ar_pre_wr got=%0b exp=1", wr); end
      checks++; if (busyB !== 1'b1) begin failures++; $display("FAIL ar_pre_busy got=%0b exp=1", busyB); end
      #2;
      reset = 1;
      #1;
      checks++; if (wr !== 1'b0) begin failures++; $display("FAIL ar_wr got=%0b exp=0", wr); end
      checks++; if (waddr !== 5'd0) begin failures++; $display("FAIL ar_waddr got=%0d exp=0", waddr); end
      checks++; if (wdata !== 32'd0) begin failures++; $display("FAIL ar_wdata got=%h exp=0", wdata); end
      checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL ar_busyA got=%0b exp=0", busyA); end
      checks++; if (busyB !== 1'b0) begin failures++; $display("FAIL ar_busyB got=%0b exp=0", busyB); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL ar_idle got=%0b exp=1", idle); end
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_random();
      bit          busy[32];
      bit          m_wr;
      logic [4:0]  m_waddr, a;
      logic [31:0] m_wdata;
      int          last, nbusy;
      bit          hold0, hold1, e0, e1;
      do_reset();
      foreach (busy[k]) busy[k] = 0;
      m_wr = 0; m_waddr = 0; m_wdata = 0;
      last = 1; hold0 = 0; hold1 = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!hold0) begin
            req0_valid = ($urandom_range(0, 1) == 1);
            req0_addr = 5'($urandom);
            req0_data = $urandom;
         end
         if (!hold1) begin
            req1_valid = ($urandom_range(0, 1) == 1);
            req1_addr = 5'($urandom);
            req1_data = $urandom;
         end
         issue_valid = ($urandom_range(0, 9) < 4);
         issue_rd = 5'($urandom);
         raddrA = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         raddrB = 5'($urandom);
         #1;
         if (req0_valid && req1_valid) begin
            e0 = !RR || (last == 1);
            e1 = !e0;
         end else begin
            e0 = req0_valid;
            e1 = req1_valid;
         end
         nbusy = 0;
         foreach (busy[k]) nbusy += busy[k];
         checks++; if (req0_ready !== e0) begin failures++; $display("FAIL rnd_ready0 c=%0d got=%0b exp=%0b", c, req0_ready, e0); end
         checks++; if (req1_ready !== e1) begin failures++; $display("FAIL rnd_ready1 c=%0d got=%0b exp=%0b", c, req1_ready, e1); end
         checks++; if (busyA !== (raddrA != 0 && busy[raddrA])) begin failures++; $display("FAIL rnd_busyA c=%0d r=%0d got=%0b", c, raddrA, busyA); end
         checks++; if (busyB !== (raddrB != 0 && busy[raddrB])) begin failures++; $display("FAIL rnd_busyB c=%0d r=%0d got=%0b", c, raddrB, busyB); end
         checks++; if (wr !== m_wr) begin failures++; $display("FAIL rnd_wr c=%0d got=%0b exp=%0b", c, wr, m_wr); end
         checks++; if (waddr !== m_waddr) begin failures++; $display("FAIL rnd_waddr c=%0d got=%0d exp=%0d", c, waddr, m_waddr); end
         checks++; if (wdata !== m_wdata) begin failures++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, wdata, m_wdata); end
         checks++; if (idle !== (nbusy == 0 && !m_wr)) begin failures++; $display("FAIL rnd_idle c=%0d got=%0b", c, idle); end
         m_wr = 0;
         if (e0 || e1) begin
            a = e1 ? req1_addr : req0_addr;
            m_wr = (a != 0);
            m_waddr = a;
            m_wdata = e1 ? req1_data : req0_data;
            last = e1 ? 1 : 0;
            busy[a] = 0;
         end
         if (issue_valid && issue_rd != 0) busy[issue_rd] = 1;
         hold0 = req0_valid && !e0;
         hold1 = req1_valid && !e1;
      end
      @(negedge clk);
      clr_inputs();
   endtask

   initial begin
      reset = 1;
      clr_inputs();
      raddrA = 0; raddrB = 0;
      test_reset();
      test_raw_hazard();
      test_contention();
      test_x0();
      test_set_clear_same_cycle();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
